// File: rtl/um_pkt_arbiter_pkg.sv
// Shared definitions for the um packet-input arbiter: word tags, tag field
// position and FSM state encoding.
package um_pkt_arbiter_pkg;

  localparam int unsigned TAG_MSB = 133;
  localparam int unsigned TAG_LSB = 132;

  localparam logic [1:0] TAG_ILL  = 2'b00;
  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_TAIL = 2'b10;
  localparam logic [1:0] TAG_BODY = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS0 = 2'd1,
    ST_PASS1 = 2'd2
  } state_t;

endpackage

// File: rtl/um_rr_arb2.sv
// Two-way round-robin pick; 'last' remembers the port that most recently
// finished a packet so the other port wins the next contest.
module um_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_port,
  output logic [1:0] pick
);

  logic last;

  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   last <= 1'b1;
    else if (upd) last <= upd_port;
  end

endmodule

// File: rtl/um_pkt_arbiter.sv
// Packet-granular two-input arbiter merging network and DMA streams onto the
// um pktin bus; grant is held from head to tail, with per-port statistics.
module um_pkt_arbiter
  import um_pkt_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 134,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_req,
  input  logic              in0_data_wr,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_req,
  input  logic              in1_data_wr,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  input  logic              out_ready,
  output logic              out_data_wr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid_wr,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic [CNT_W-1:0]  err_cnt
);

  state_t            state, state_nxt;
  logic              first;
  logic [1:0]        pick;
  logic              acc;
  logic [DATA_W-1:0] acc_data;
  logic [1:0]        acc_tag;
  logic              is_tail;
  logic              is_err;

  um_rr_arb2 u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({in1_req, in0_req}),
    .upd      (is_tail),
    .upd_port (state == ST_PASS1),
    .pick     (pick)
  );

  always_comb begin
    in0_ready = (state == ST_PASS0) & out_ready;
    in1_ready = (state == ST_PASS1) & out_ready;
    grant     = {state == ST_PASS1, state == ST_PASS0};
    acc       = (in0_data_wr & in0_ready) | (in1_data_wr & in1_ready);
    acc_data  = (state == ST_PASS1) ? in1_data : in0_data;
    acc_tag   = acc_data[TAG_MSB:TAG_LSB];
    is_tail   = acc && (acc_tag == TAG_TAIL);
    // A tag-00 first word counts once even though it also isn't a head.
    is_err    = acc && ((acc_tag == TAG_ILL) ||
                        (first ? (acc_tag != TAG_HEAD) : (acc_tag == TAG_HEAD)));
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pick[0])      state_nxt = ST_PASS0;
        else if (pick[1]) state_nxt = ST_PASS1;
      end
      ST_PASS0, ST_PASS1: begin
        if (is_tail) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      first <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE) first <= 1'b1;
      else if (acc)         first <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_wr  <= 1'b0;
      out_valid_wr <= 1'b0;
      out_data     <= '0;
      pkt_cnt0     <= '0;
      pkt_cnt1     <= '0;
      err_cnt      <= '0;
    end else begin
      out_data_wr  <= acc;
      out_valid_wr <= is_tail;
      if (acc) out_data <= acc_data;
      if (is_tail && state == ST_PASS0) pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      if (is_tail && state == ST_PASS1) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
      if (is_err) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_um_pkt_arbiter.sv
// Scoreboard bench for um_pkt_arbiter: directed packets, expected words queued
// up front in arbitration order, popped by a monitor on every output strobe.
module tb_um_pkt_arbiter;
  import um_pkt_arbiter_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in0_req, in0_data_wr, in0_ready;
  logic [133:0] in0_data;
  logic         in1_req, in1_data_wr, in1_ready;
  logic [133:0] in1_data;
  logic         out_ready, out_data_wr, out_valid_wr;
  logic [133:0] out_data;
  logic [1:0]   grant;
  logic [31:0]  pkt_cnt0, pkt_cnt1, err_cnt;

  typedef struct {
    logic [133:0] d;
    logic         tl;
  } exp_t;

  exp_t         expq[$];
  logic [133:0] q0[$];
  logic [133:0] q1[$];
  int           compared   = 0;
  int           mismatched = 0;
  int unsigned  e_pkt0 = 0, e_pkt1 = 0, e_err = 0;

  um_pkt_arbiter #(.DATA_W(134), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_req(in0_req), .in0_data_wr(in0_data_wr), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_req(in1_req), .in1_data_wr(in1_data_wr), .in1_data(in1_data), .in1_ready(in1_ready),
    .out_ready(out_ready), .out_data_wr(out_data_wr), .out_data(out_data),
    .out_valid_wr(out_valid_wr), .grant(grant),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [133:0] act, input logic [133:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  function automatic logic [133:0] mkw(input logic [1:0] t, input logic [31:0] v);
    return {t, 100'd0, v};
  endfunction

  task automatic add_word(input bit p, input logic [1:0] t, input logic [31:0] v);
    exp_t e;
    e.d  = mkw(t, v);
    e.tl = (t == TAG_TAIL);
    expq.push_back(e);
    if (p) q1.push_back(e.d);
    else   q0.push_back(e.d);
  endtask

  task automatic add_std(input bit p, input int n, input logic [31:0] base);
    add_word(p, TAG_HEAD, base);
    for (int i = 1; i < n - 1; i++) add_word(p, TAG_BODY, base + 32'(i));
    add_word(p, TAG_TAIL, base + 32'(n - 1));
  endtask

  // Called at a negedge; each word is held until ready is seen before a rising edge.
  task automatic drive_port(input bit p);
    logic [133:0] w;
    logic         rdy;
    int           guard;
    while ((p ? q1.size() : q0.size()) != 0) begin
      if (p) begin w = q1.pop_front(); in1_req = 1'b1; in1_data_wr = 1'b1; in1_data = w; end
      else   begin w = q0.pop_front(); in0_req = 1'b1; in0_data_wr = 1'b1; in0_data = w; end
      guard = 0;
      rdy   = 1'b0;
      while (!rdy && guard < 200) begin
        #4;
        rdy = p ? in1_ready : in0_ready;
        @(negedge clk);
        guard++;
      end
      if (!rdy) begin
        compared++;
        mismatched++;
        $display("FAIL accept_timeout port %0d: got ready=0 expected ready=1", p);
      end
    end
    if (p) begin in1_req = 1'b0; in1_data_wr = 1'b0; end
    else   begin in0_req = 1'b0; in0_data_wr = 1'b0; end
  endtask

  task automatic drain();
    int guard = 0;
    while (expq.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    check("drain_left", 134'(expq.size()), 134'd0);
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_pkt_cnt0"}, 134'(pkt_cnt0), 134'(e_pkt0));
    check({tag, "_pkt_cnt1"}, 134'(pkt_cnt1), 134'(e_pkt1));
    check({tag, "_err_cnt"},  134'(err_cnt),  134'(e_err));
    check({tag, "_grant"},    134'(grant),    134'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && out_data_wr === 1'b1) begin
      if (expq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_word: got %0h expected none", out_data);
      end else begin
        e = expq.pop_front();
        check("out_data", out_data, e.d);
        check("out_valid_wr", 134'(out_valid_wr), 134'(e.tl));
      end
    end else if (rst_n === 1'b1 && out_valid_wr === 1'b1) begin
      check("valid_without_wr", 134'(out_valid_wr), 134'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int guard;
    rst_n = 1'b0; out_ready = 1'b1;
    in0_req = 1'b0; in0_data_wr = 1'b0; in0_data = '0;
    in1_req = 1'b0; in1_data_wr = 1'b0; in1_data = '0;
    repeat (3) @(negedge clk);
    check("rst_grant", 134'(grant), 134'd0);
    check("rst_in0_ready", 134'(in0_ready), 134'd0);
    check("rst_in1_ready", 134'(in1_ready), 134'd0);
    check("rst_out_data_wr", 134'(out_data_wr), 134'd0);
    check("rst_out_valid_wr", 134'(out_valid_wr), 134'd0);
    check("rst_out_data", out_data, 134'd0);
    check_cnts("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Both ports contend from reset: port 0 first, then strict alternation.
    add_std(0, 3, 32'h200);
    add_std(1, 2, 32'h210);
    add_std(0, 4, 32'h220);
    add_std(1, 3, 32'h230);
    fork
      drive_port(0);
      drive_port(1);
    join
    drain();
    e_pkt0 = 2; e_pkt1 = 2;
    check_cnts("rr");

    add_std(0, 3, 32'h100);
    drive_port(0);
    drain();
    e_pkt0 = 3;
    check_cnts("single");

    // Downstream stalls for 5 cycles in the middle of a 6-word packet.
    add_std(0, 6, 32'h300);
    fork
      drive_port(0);
      begin
        guard = 0;
        while (grant !== 2'b01 && guard < 50) begin @(negedge clk); guard++; end
        check("bp_grant", 134'(grant), 134'd1);
        repeat (2) @(negedge clk);
        n = out_data_wr ? 1 : 0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          #1;
          check("bp_in0_ready", 134'(in0_ready), 134'd0);
          @(negedge clk);
          if (out_data_wr) n++;
        end
        out_ready = 1'b1;
        check("bp_words_after_drop_le1", 134'(n <= 1), 134'd1);
      end
    join
    drain();
    e_pkt0 = 4;
    check_cnts("bp");

    // First word of a grant is a body: forwarded, one error, grant released.
    add_word(1, TAG_BODY, 32'h400);
    add_word(1, TAG_TAIL, 32'h401);
    drive_port(1);
    drain();
    e_pkt1 = 3; e_err = 1;
    check_cnts("err");

    // Reset pulsed after the head of a 4-word packet.
    begin
      exp_t e;
      in0_req = 1'b1;
      guard = 0;
      while (in0_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
      check("rst_mid_ready", 134'(in0_ready), 134'd1);
      in0_data_wr = 1'b1;
      in0_data    = mkw(TAG_HEAD, 32'h500);
      e.d = in0_data; e.tl = 1'b0;
      expq.push_back(e);
      @(negedge clk);
      in0_data_wr = 1'b0;
      in0_data    = mkw(TAG_BODY, 32'h501);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_data_wr", 134'(out_data_wr), 134'd0);
      check("arst_out_data", out_data, 134'd0);
      check("arst_grant", 134'(grant), 134'd0);
      check("arst_in0_ready", 134'(in0_ready), 134'd0);
      check("arst_pkt_cnt0", 134'(pkt_cnt0), 134'd0);
      check("arst_pkt_cnt1", 134'(pkt_cnt1), 134'd0);
      check("arst_err_cnt", 134'(err_cnt), 134'd0);
      in0_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end
    e_pkt0 = 0; e_pkt1 = 0; e_err = 0;
    add_std(0, 3, 32'h520);
    add_std(1, 2, 32'h530);
    fork
      drive_port(0);
      drive_port(1);
    join
    drain();
    e_pkt0 = 1; e_pkt1 = 1;
    check_cnts("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/um_pkt_arbiter.md
# um_pkt_arbiter

Packet-granular two-input arbiter in front of the `um` packet input path. It merges the network ingress stream and the DMA-injected stream into the single 134-bit `pktin_data` bus consumed by the TuMan32 packet datapath. Grants are round-robin and held for a whole packet, from head word to tail word, so packets are never interleaved. Per-port packet and protocol-error counters are exposed for the control path.

## Interface
Parameters:
- `DATA_W`, 134, packet word width; bits [133:132] are the word tag.
- `CNT_W`, 32, width of each statistics counter.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in0_req`  in  1  port 0 (network) has a packet pending.
- `in0_data_wr`  in  1  port 0 word strobe.
- `in0_data`  in  DATA_W  port 0 word.
- `in0_ready`  out  1  port 0 may write this cycle.
- `in1_req`, `in1_data_wr`, `in1_data`, `in1_ready`: same as port 0, for port 1 (DMA).
- `out_ready`  in  1  downstream not almost-full.
- `out_data_wr`  out  1  output word strobe (registered).
- `out_data`  out  DATA_W  output word (registered).
- `out_valid_wr`  out  1  one-cycle pulse together with the tail word.
- `grant`  out  2  current owner, one-hot; 00 when idle.
- `pkt_cnt0`, `pkt_cnt1`  out  CNT_W  tails forwarded per port.
- `err_cnt`  out  CNT_W  protocol errors, both ports combined.

## Operation
- Tag encoding: 01 = head, 11 = body, 10 = tail, 00 = illegal. A packet is at least 2 words (head, then tail).
- FSM states:
  - IDLE: `grant` = 00 and both readies are low. If exactly one `req` is high, grant that port. If both are high, grant the port other than `last`. Go to PASS0 or PASS1. With no `req`, stay in IDLE.
  - PASSk: `ink_ready` = `out_ready`; the other port's ready = 0. A word is accepted when `ink_data_wr & ink_ready`. Each accepted word is copied to `out_data` and `out_data_wr` = 1 on the next cycle.
  - An accepted tail (10) causes: `last` <= k, `pkt_cntk` += 1, `out_valid_wr` pulses with that word, and the FSM returns to IDLE.
- Protocol errors increment `err_cnt`; the offending word is still forwarded:
  - first word of a grant is not a head;
  - a head arrives mid-packet;
  - tag 00.
- A head arriving mid-packet does not end the grant. Only a tail releases it.
- `ink_data_wr` while `ink_ready` = 0 is ignored; the word is not accepted.
- Counters wrap modulo 2^CNT_W. `err_cnt` can increment at most once per cycle, since only one port is active at a time.
- `req` is sampled only in IDLE. Dropping `req` mid-packet does not release the grant.

## Timing
- Reset values:
  - FSM = IDLE;
  - `last` = 1, so port 0 wins the first contest;
  - `grant` = 00, all readies = 0;
  - `out_data_wr` = 0, `out_valid_wr` = 0, `out_data` = 0;
  - all counters = 0.
- Reset asserted mid-packet aborts the packet immediately; no tail is emitted.
- Latency: accepted input word to `out_data_wr` = 1 cycle.
- Arbitration: `req` high in IDLE gives `grant` and ready on the next cycle. There is one dead cycle between back-to-back packets.
- Backpressure: `ink_ready` follows `out_ready` combinationally. Downstream must tolerate 1 word after deasserting `out_ready`, which matches almost-full semantics.
- Tail accepted in cycle t: FSM is in IDLE in cycle t+1, and the next grant is visible in t+2.

## Structure
- Shared package holds:
  - tag constants TAG_HEAD, TAG_BODY, TAG_TAIL, TAG_ILL;
  - tag field position [133:132];
  - FSM state encoding.
- One sub-module, `um_rr_arb2`: 2-way round-robin pick with `last` pointer update. Everything else stays in the top.

## Test plan
- Only port 0: `in0_req`=1, packet head/body/tail -> 3 identical words on `out_data` 1 cycle later; `out_valid_wr` with the tail; `pkt_cnt0`=1; `err_cnt`=0.
- Both `req` high after reset, 2 packets each -> output order P0, P1, P0, P1; no word interleaving; `pkt_cnt0`=`pkt_cnt1`=2.
- `out_ready` low for 5 cycles mid-packet -> owner's ready low for those 5 cycles; at most 1 word emitted after the drop; data order intact.
- Port 1 first word tagged body, then tail -> both words forwarded; `err_cnt`=1; `pkt_cnt1`=1; grant released.
- `rst_n` pulsed low after the head of a 4-word packet -> outputs return to reset values asynchronously; a fresh packet afterwards is forwarded correctly with port 0 priority.
